uart_tx_fifo_8n1: RTL and testbench

- UART transmitter, 8N1, LSB first, idle-high line. Pairs with the on-chip UART receiver on the same link.
- A small byte FIFO decouples the valid/ready producer (host logic) from serial timing.
- Consecutive queued bytes go out back-to-back with no idle gap.
- Sits between application logic and the FPGA TX pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_byte_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo_8n1.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo_8n1.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the on-chip receiver.
//   UART_CLK_HZ / UART_BAUD / UART_CLKS_PER_BIT : default link timing
//   TX_* / tx_state_t                            : transmitter FSM encoding
//   FRAME_BITS                                   : 8N1 frame length in bit times
package uart_pkg;

  localparam int UART_CLK_HZ       = 12_000_000;
  localparam int UART_BAUD         = 115_200;
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = TX_IDLE,
    ST_START = TX_START,
    ST_DATA  = TX_DATA,
    ST_STOP  = TX_STOP
  } tx_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO used to queue bytes ahead of the serializer.
//   clk, rst_n : clock and asynchronous active-low reset (clears pointers/count)
//   push, din  : write din when push is high and the FIFO is not full
//   pop        : drop the head entry when pop is high and the FIFO is not empty
//   dout       : head entry, combinational
//   count      : number of stored entries
//   full/empty : derived from the registered count
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_8n1.sv
// 8N1 UART transmitter (LSB first, idle-high) fed by a small byte FIFO.
//   clk, rst_n  : clock and asynchronous active-low reset
//   tx_enable   : allows a new frame to start; a running frame always completes
//   tx_data     : byte to queue, sampled only on an accepted push
//   tx_valid    : producer has a byte; push happens when tx_valid && tx_ready
//   tx_ready    : FIFO not full (from the registered count)
//   tx          : registered serial line
//   busy        : high from start-bit launch to the end of the last stop bit
//   fifo_count  : bytes waiting, not counting the one being shifted
module uart_tx_fifo_8n1
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = UART_CLK_HZ,
  parameter int BAUD         = UART_BAUD,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tx_enable,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_q;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              baud_last;
  logic              can_start;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign can_start = tx_enable && !fifo_empty;
  // A new frame launches from IDLE, or straight out of the last stop-bit
  // cycle so consecutive bytes leave with no idle gap.
  assign fifo_pop  = can_start && ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));
  assign fifo_push = tx_valid && !fifo_full;
  assign tx_ready  = !fifo_full;

  uart_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The byte in flight lives here; loaded on the same edge the start bit launches.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shift_q <= fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (fifo_pop) begin
            state <= ST_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            tx       <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_8n1.sv
// Self-checking bench for uart_tx_fifo_8n1: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue/frame-position model of the transmitter.
module tb_uart_tx_fifo_8n1;

  localparam int CPB   = 12000000 / 115200;  // 104
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_enable;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo_8n1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_enable  (tx_enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // ---------------- behavioural model ----------------
  // Queue of waiting bytes; a frame in flight is a 10-bit pattern
  // {stop, data, start} and a cycle position 0..FRAME-1 within it.
  logic [7:0] mq[$];
  bit         m_active;
  int         m_pos;
  logic [9:0] m_frame;
  int         m_depth_before;
  bit         m_push;
  bit         m_start;

  function automatic logic m_tx();
    return m_active ? m_frame[m_pos / CPB] : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      m_depth_before = mq.size();
      m_push  = tx_valid && (m_depth_before < DEPTH);
      m_start = 1'b0;
      if (m_active) begin
        if (m_pos == FRAME - 1) begin
          m_active = 1'b0;
          m_start  = tx_enable && (m_depth_before > 0);
        end else begin
          m_pos++;
        end
      end else begin
        m_start = tx_enable && (m_depth_before > 0);
      end
      if (m_start) begin
        m_frame  = {1'b1, mq.pop_front(), 1'b0};
        m_pos    = 0;
        m_active = 1'b1;
      end
      if (m_push) mq.push_back(tx_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("tx", 32'(tx), 32'(m_tx()));
      chk("busy", 32'(busy), 32'(m_active));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("tx_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  int burst_left;

  initial begin
    rst_n     = 1'b0;
    tx_enable = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    // Reset
    repeat (5) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    repeat (2000) @(posedge clk);
    #1;
    chk("idle_tx", 32'(tx), 32'd1);

    // Single byte 0xA5: start low k+1..k+104, bits LSB first, busy falls at k+1041
    @(negedge clk);
    tx_enable = 1'b1;
    push_byte(8'hA5);
    @(posedge clk); #1;                       // k+1
    chk("a5_start_first", 32'(tx), 32'd0);
    chk("a5_busy_rise", 32'(busy), 32'd1);
    repeat (103) @(posedge clk); #1;          // k+104
    chk("a5_start_last", 32'(tx), 32'd0);
    @(posedge clk); #1;                       // k+105
    chk("a5_bit0", 32'(tx), 32'd1);
    repeat (104) @(posedge clk); #1;          // k+209
    chk("a5_bit1", 32'(tx), 32'd0);
    repeat (831) @(posedge clk); #1;          // k+1040
    chk("a5_busy_last", 32'(busy), 32'd1);
    chk("a5_stop", 32'(tx), 32'd1);
    @(posedge clk); #1;                       // k+1041
    chk("a5_busy_fall", 32'(busy), 32'd0);

    // Queue fill, held push while full, then five back-to-back frames
    @(negedge clk);
    tx_enable = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_ready", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_hold_count", 32'(fifo_count), 32'd4);
    tx_enable = 1'b1;
    @(posedge clk); #1;                       // p: first pop, push refused
    chk("pop_edge_count", 32'(fifo_count), 32'd3);
    chk("pop_edge_tx", 32'(tx), 32'd0);
    chk("pop_edge_ready", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;                       // p+1: 0x55 accepted
    chk("late_push_count", 32'(fifo_count), 32'd4);
    chk("late_push_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (1039) @(posedge clk); #1;         // p+1040: second start, no gap
    chk("b2b_start", 32'(tx), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    repeat (4159) @(posedge clk); #1;         // p+5199
    chk("five_busy_last", 32'(busy), 32'd1);
    @(posedge clk); #1;                       // p+5200
    chk("five_busy_fall", 32'(busy), 32'd0);
    chk("five_empty", 32'(fifo_count), 32'd0);

    // tx_enable dropped during bit 3 of 0x3C with 0x99 queued
    push_byte(8'h3C);                         // frame starts s = k+1
    push_byte(8'h99);
    repeat (450) @(posedge clk);              // s+451, inside bit 3
    @(negedge clk);
    tx_enable = 1'b0;
    repeat (600) @(posedge clk); #1;          // s+1051, frame done
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_tx", 32'(tx), 32'd1);
    chk("dis_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    tx_enable = 1'b1;
    @(posedge clk); #1;
    chk("reen_tx", 32'(tx), 32'd0);
    chk("reen_busy", 32'(busy), 32'd1);
    chk("reen_count", 32'(fifo_count), 32'd0);
    repeat (1045) @(posedge clk);

    // Reset asserted during data bit 5
    push_byte(8'hC3);
    push_byte(8'h0F);
    repeat (650) @(posedge clk);              // s+651, inside bit 5
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) @(posedge clk); #1;
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic with bursts and enable toggling
    burst_left = 0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (burst_left == 0 && $urandom_range(0, 299) == 0)
        burst_left = $urandom_range(1, 7);
      tx_valid = (burst_left > 0) || ($urandom_range(0, 255) == 0);
      if (burst_left > 0) burst_left--;
      tx_data = 8'($urandom);
      if ($urandom_range(0, 1999) == 0) tx_enable = ~tx_enable;
    end
    @(negedge clk);
    tx_valid  = 1'b0;
    tx_enable = 1'b1;
    repeat (6000) @(posedge clk); #1;
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
